perceptron_trainer: RTL

Sequential training and inference controller for the 2-input 4-bit signed perceptron used in the tile. It accepts one labelled sample at a time over a valid/ready handshake and evaluates the weighted sum `w1*x1 + w2*x2 + b`. It returns the predicted class and, when training is enabled, applies the perceptron learning rule to its internal weight and bias registers. The design sits between the sample source (pin/host interface) and any logic that reads back learned weights or error statistics.

---
 rtl/perceptron_trainer_if.sv | 23 ++
 rtl/perceptron_trainer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/perceptron_trainer_if.sv
// Sample/result handshake bundle for the perceptron trainer.
// The master side is the sample source and result consumer; the slave side is the trainer.
interface perceptron_trainer_if;
    logic              s_valid;
    logic              s_ready;
    logic signed [3:0] s_x1;
    logic signed [3:0] s_x2;
    logic              s_label;
    logic              r_valid;
    logic              r_ready;
    logic              r_pred;
    logic              r_err;

    modport master (
        output s_valid, s_x1, s_x2, s_label, r_ready,
        input  s_ready, r_valid, r_pred, r_err
    );

    modport slave (
        input  s_valid, s_x1, s_x2, s_label, r_ready,
        output s_ready, r_valid, r_pred, r_err
    );
endinterface

// File: rtl/perceptron_trainer.sv
// Sequential 2-input perceptron: evaluates w1*x1 + w2*x2 + bias for one sample,
// reports the predicted class and, when training, applies the perceptron rule
// with saturating weight and bias registers.
module perceptron_trainer #(
    parameter int WW      = 6,
    parameter int BW      = 8,
    parameter int W1_INIT = 2,
    parameter int W2_INIT = -2,
    parameter int B_INIT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  train_en,
    input  logic                  clr_cnt,
    perceptron_trainer_if.slave   bus,
    output logic signed [WW-1:0]  w1,
    output logic signed [WW-1:0]  w2,
    output logic signed [BW-1:0]  bias,
    output logic [7:0]            err_cnt
);

    // Sum width large enough that neither products nor the bias add can overflow;
    // the same width also hosts the unclamped update results.
    localparam int SW    = ((WW + 4) > BW ? (WW + 4) : BW) + 2;
    localparam int W_MAX = (1 << (WW - 1)) - 1;
    localparam int W_MIN = -(1 << (WW - 1));
    localparam int B_MAX = (1 << (BW - 1)) - 1;
    localparam int B_MIN = -(1 << (BW - 1));

    typedef enum logic [1:0] {IDLE, MAC, UPD, RESP} state_t;

    state_t state;
    state_t state_nxt;

    logic signed [3:0]    x1_p0;
    logic signed [3:0]    x2_p0;
    logic                 label_p0;
    logic                 train_p0;

    logic signed [SW-1:0] sum_p0;
    logic                 pred_c;
    logic                 pred_p1;
    logic                 err_p1;

    logic signed [SW-1:0] d1;
    logic signed [SW-1:0] d2;
    logic signed [SW-1:0] db;
    logic signed [WW-1:0] w1_upd;
    logic signed [WW-1:0] w2_upd;
    logic signed [BW-1:0] b_upd;

    function automatic logic signed [WW-1:0] sat_w(input logic signed [SW-1:0] v);
        if (v > SW'(W_MAX))
            sat_w = WW'(W_MAX);
        else if (v < SW'(W_MIN))
            sat_w = WW'(W_MIN);
        else
            sat_w = v[WW-1:0];
    endfunction

    function automatic logic signed [BW-1:0] sat_b(input logic signed [SW-1:0] v);
        if (v > SW'(B_MAX))
            sat_b = BW'(B_MAX);
        else if (v < SW'(B_MIN))
            sat_b = BW'(B_MIN);
        else
            sat_b = v[BW-1:0];
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: one sample walks IDLE -> MAC -> UPD -> RESP and waits there for the consumer
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.s_valid) state_nxt = MAC;
            MAC:     state_nxt = UPD;
            UPD:     state_nxt = RESP;
            RESP:    if (bus.r_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state; ready is masked while reset is held
    always_comb begin
        bus.s_ready = (state == IDLE) && !rst;
        bus.r_valid = (state == RESP);
        bus.r_pred  = pred_p1;
        bus.r_err   = err_p1;
    end

    // Stage p0: capture the accepted sample and its training mode
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.s_valid) begin
            x1_p0    <= bus.s_x1;
            x2_p0    <= bus.s_x2;
            label_p0 <= bus.s_label;
            train_p0 <= train_en;
        end
    end

    // Weighted sum of the captured sample against the current weights
    always_comb begin
        sum_p0 = SW'(w1) * SW'(x1_p0) + SW'(w2) * SW'(x2_p0) + SW'(bias);
        pred_c = (sum_p0 >= 0);
    end

    // Stage p1: register the prediction and the error flag in MAC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_p1 <= 1'b0;
            err_p1  <= 1'b0;
        end else if (state == MAC) begin
            pred_p1 <= pred_c;
            err_p1  <= (pred_c != label_p0);
        end
    end

    // Learning rule in widened arithmetic: step toward the label, then clamp
    always_comb begin
        d1     = label_p0 ? SW'(x1_p0) : -SW'(x1_p0);
        d2     = label_p0 ? SW'(x2_p0) : -SW'(x2_p0);
        db     = label_p0 ? SW'(1) : -SW'(1);
        w1_upd = sat_w(SW'(w1) + d1);
        w2_upd = sat_w(SW'(w2) + d2);
        b_upd  = sat_b(SW'(bias) + db);
    end

    // Stage p2: weights and bias change only on a misclassified training sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w1   <= WW'(W1_INIT);
            w2   <= WW'(W2_INIT);
            bias <= BW'(B_INIT);
        end else if (state == UPD && train_p0 && err_p1) begin
            w1   <= w1_upd;
            w2   <= w2_upd;
            bias <= b_upd;
        end
    end

    // Saturating error counter; an explicit clear overrides a coincident increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= '0;
        else if (clr_cnt)
            err_cnt <= '0;
        else if (state == UPD && err_p1 && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end

endmodule
